// File: rtl/cache_fill_fsm_pkg.sv
// Shared cache geometry, metadata field layout and fill-controller state encoding.
package cache_fill_fsm_pkg;
   localparam int unsigned ADDR_W      = 16;
   localparam int unsigned DATA_W      = 16;
   localparam int unsigned TAG_W       = 8;
   localparam int unsigned IDX_W       = 4;
   localparam int unsigned WORDS       = 8;
   localparam int unsigned NBLK        = 32;
   localparam int unsigned CNT_W       = 3;
   localparam int unsigned BLK_W       = 5;
   localparam int unsigned META_W      = 10;
   localparam int unsigned META_VALID  = 9;
   localparam int unsigned META_LRU    = 8;
   localparam int unsigned META_TAG_HI = 7;
   localparam int unsigned META_TAG_LO = 0;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_FILL   = 2'd1;
   localparam state_t ST_TAG_WR = 2'd2;

   // A freshly filled line is valid and most recently used.
   function automatic logic [META_W-1:0] meta_entry(input logic [TAG_W-1:0] tag);
      logic [META_W-1:0] e;
      e = '0;
      e[META_VALID] = 1'b1;
      e[META_LRU] = 1'b1;
      e[META_TAG_HI:META_TAG_LO] = tag;
      return e;
   endfunction
endpackage

// File: rtl/cache_fill_fsm_if.sv
// Miss request, memory read bus, and data/metadata array write ports of the fill controller.
interface cache_fill_fsm_if;
   import cache_fill_fsm_pkg::*;

   logic                miss_detected;
   logic [ADDR_W-1:0]   miss_address;
   logic                victim_way;
   logic                mem_en;
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_data_valid;
   logic [DATA_W-1:0]   mem_data;
   logic                data_we;
   logic [NBLK-1:0]     data_block_en;
   logic [WORDS-1:0]    data_word_en;
   logic [DATA_W-1:0]   data_out;
   logic                meta_we;
   logic [NBLK-1:0]     meta_block_en;
   logic [META_W-1:0]   meta_out;
   logic                busy;
   logic                fill_done;

   modport master (
      input  miss_detected, miss_address, victim_way, mem_data_valid, mem_data,
      output mem_en, mem_addr, data_we, data_block_en, data_word_en, data_out,
      output meta_we, meta_block_en, meta_out, busy, fill_done
   );

   modport slave (
      output miss_detected, miss_address, victim_way, mem_data_valid, mem_data,
      input  mem_en, mem_addr, data_we, data_block_en, data_word_en, data_out,
      input  meta_we, meta_block_en, meta_out, busy, fill_done
   );
endinterface

// File: rtl/cache_fill_fsm_fill_counter.sv
// 3-bit word counter with clear and a sticky flag set when the count wraps past the last word.
module cache_fill_fsm_fill_counter
   import cache_fill_fsm_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             done
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;

   always_comb begin
      cnt_d  = cnt_q;
      done_d = done_q;
      if (clr) begin
         cnt_d  = '0;
         done_d = 1'b0;
      end else if (en && !done_q) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == '1) done_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign cnt  = cnt_q;
   assign done = done_q;
endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: streams an 8-word block from memory into the data array,
// then writes the new metadata entry for that block.
module cache_fill_fsm
   import cache_fill_fsm_pkg::*;
(
   input logic             clk,
   input logic             rst,
   cache_fill_fsm_if.master bus
);
   state_t             state_q, state_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               way_q, way_d;
   logic [CNT_W-1:0]   issue_cnt, recv_cnt;
   logic               issue_done, recv_done;
   logic               cnt_clr, issue_en, recv_en;
   logic [BLK_W-1:0]   blk;
   logic               unused_offset;

   cache_fill_fsm_fill_counter u_issue_cnt (
      .clk (clk), .rst (rst), .clr (cnt_clr), .en (issue_en),
      .cnt (issue_cnt), .done (issue_done)
   );

   cache_fill_fsm_fill_counter u_recv_cnt (
      .clk (clk), .rst (rst), .clr (cnt_clr), .en (recv_en),
      .cnt (recv_cnt), .done (recv_done)
   );

   always_comb begin
      state_d  = state_q;
      tag_d    = tag_q;
      idx_d    = idx_q;
      way_d    = way_q;
      cnt_clr  = 1'b0;
      issue_en = (state_q == ST_FILL) && !issue_done;
      recv_en  = (state_q == ST_FILL) && bus.mem_data_valid && !recv_done;
      case (state_q)
         ST_IDLE: begin
            if (bus.miss_detected) begin
               tag_d   = bus.miss_address[15:8];
               idx_d   = bus.miss_address[7:4];
               way_d   = bus.victim_way;
               cnt_clr = 1'b1;
               state_d = ST_FILL;
            end
         end
         ST_FILL:   if (recv_en && recv_cnt == '1) state_d = ST_TAG_WR;
         ST_TAG_WR: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         tag_q   <= '0;
         idx_q   <= '0;
         way_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         idx_q   <= idx_d;
         way_q   <= way_d;
      end
   end

   // Every output is gated by its strobe so the whole bus reads zero outside an active fill.
   always_comb begin
      blk               = {idx_q, way_q};
      unused_offset     = ^bus.miss_address[3:0];
      bus.mem_en        = issue_en;
      bus.mem_addr      = issue_en ? {tag_q, idx_q, issue_cnt, 1'b0} : '0;
      bus.data_we       = recv_en;
      bus.data_word_en  = recv_en ? (WORDS'(1) << recv_cnt) : '0;
      bus.data_block_en = recv_en ? (NBLK'(1) << blk) : '0;
      bus.data_out      = recv_en ? bus.mem_data : '0;
      bus.meta_we       = (state_q == ST_TAG_WR);
      bus.meta_block_en = bus.meta_we ? (NBLK'(1) << blk) : '0;
      bus.meta_out      = bus.meta_we ? meta_entry(tag_q) : '0;
      bus.fill_done     = bus.meta_we;
      bus.busy          = (state_q != ST_IDLE);
   end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a latency/gap memory model and scoreboard queues.
module tb_cache_fill_fsm;
   import cache_fill_fsm_pkg::*;

   logic clk = 1'b0;
   logic rst;
   cache_fill_fsm_if bus();

   cache_fill_fsm dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  word_en;
      logic [31:0] blk_en;
      logic [15:0] data;
   } data_exp_t;

   typedef struct packed {
      logic [31:0] blk_en;
      logic [9:0]  meta;
   } meta_exp_t;

   typedef struct {
      int          cycle;
      logic [15:0] data;
   } resp_t;

   logic [15:0] exp_addr_q[$];
   data_exp_t   exp_data_q[$];
   meta_exp_t   exp_meta_q[$];
   resp_t       resp_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lat = 4;
   int gap_max = 0;
   int last_resp = 0;
   int we_cnt = 0;
   int done_cnt = 0;
   int req_cnt = 0;
   int done_cyc = 0;
   int miss_cyc = 0;
   int first_req_cyc = -1;
   int fill_we0 = 0;
   int fill_req0 = 0;
   logic [15:0] data_base = 16'h0;
   logic [9:0]  last_meta = '0;
   logic [31:0] last_meta_blk = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Memory model: returns word data = base + word index, at max(req+lat, prev+1+gap).
   initial begin
      bus.mem_data_valid = 1'b0;
      bus.mem_data = 16'h0;
      forever begin
         @(posedge clk);
         #1;
         if (resp_q.size() > 0 && resp_q[0].cycle == cyc) begin
            bus.mem_data_valid = 1'b1;
            bus.mem_data = resp_q[0].data;
            void'(resp_q.pop_front());
         end else begin
            bus.mem_data_valid = 1'b0;
            bus.mem_data = 16'($urandom);
         end
      end
   end

   // Monitor: scoreboards every request, data write and metadata write.
   initial begin
      int r;
      int g;
      data_exp_t de;
      meta_exp_t me;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (bus.mem_en) begin
               req_cnt++;
               if (first_req_cyc < 0) first_req_cyc = cyc;
               if (exp_addr_q.size() == 0) chk("extra_req", 32'(bus.mem_en), 32'd0);
               else chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addr_q.pop_front()));
               g = (gap_max > 0) ? int'($urandom_range(1, gap_max)) : 0;
               r = cyc + lat;
               if (r < last_resp + 1 + g) r = last_resp + 1 + g;
               resp_q.push_back('{cycle: r, data: data_base + 16'(bus.mem_addr[3:1])});
               last_resp = r;
            end
            if (bus.data_we) begin
               we_cnt++;
               chk("we_with_valid", 32'(bus.mem_data_valid), 32'd1);
               if (exp_data_q.size() == 0) chk("extra_data_we", 32'(bus.data_we), 32'd0);
               else begin
                  de = exp_data_q.pop_front();
                  chk("data_word_en", 32'(bus.data_word_en), 32'(de.word_en));
                  chk("data_block_en", bus.data_block_en, de.blk_en);
                  chk("data_out", 32'(bus.data_out), 32'(de.data));
               end
            end
            if (bus.meta_we) begin
               done_cnt++;
               done_cyc = cyc;
               last_meta = bus.meta_out;
               last_meta_blk = bus.meta_block_en;
               chk("tag_wr_after_8", 32'(exp_data_q.size()), 32'd0);
               chk("fill_done_pulse", 32'(bus.fill_done), 32'd1);
               if (exp_meta_q.size() == 0) chk("extra_meta_we", 32'(bus.meta_we), 32'd0);
               else begin
                  me = exp_meta_q.pop_front();
                  chk("meta_out", 32'(bus.meta_out), 32'(me.meta));
                  chk("meta_block_en", bus.meta_block_en, me.blk_en);
               end
            end
         end
      end
   end

   task automatic start_fill(input logic [15:0] addr, input logic way, input logic [15:0] base);
      logic [4:0]  blk;
      logic [31:0] blk_en;
      blk = {addr[7:4], way};
      blk_en = 32'(1) << blk;
      for (int k = 0; k < 8; k++) begin
         exp_addr_q.push_back({addr[15:4], 3'(k), 1'b0});
         exp_data_q.push_back('{word_en: 8'(1) << k, blk_en: blk_en, data: base + 16'(k)});
      end
      exp_meta_q.push_back('{blk_en: blk_en, meta: {2'b11, addr[15:8]}});
      data_base = base;
      first_req_cyc = -1;
      fill_we0 = we_cnt;
      fill_req0 = req_cnt;
      miss_cyc = cyc;
      bus.miss_address = addr;
      bus.victim_way = way;
      bus.miss_detected = 1'b1;
   endtask

   task automatic wait_done();
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (done_cnt != d0) break;
      end
      chk("fill_done_count", 32'(done_cnt - d0), 32'd1);
   endtask

   task automatic fill_tail(input string tag);
      chk({tag, "_we_count"}, 32'(we_cnt - fill_we0), 32'd8);
      chk({tag, "_req_count"}, 32'(req_cnt - fill_req0), 32'd8);
      chk({tag, "_sb_empty"}, 32'(exp_addr_q.size() + exp_data_q.size() + exp_meta_q.size()), 32'd0);
      chk({tag, "_first_req"}, 32'(first_req_cyc - miss_cyc), 32'd1);
   endtask

   initial begin
      int d0;
      int r0;
      int w0;
      rst = 1'b0;
      bus.miss_detected = 1'b0;
      bus.miss_address = '0;
      bus.victim_way = 1'b0;

      @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_meta_out", 32'(bus.meta_out), 32'd0);
      chk("rst_data_out", 32'(bus.data_out), 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;

      // Basic fill
      @(posedge clk);
      #1;
      start_fill(16'hA35C, 1'b1, 16'h1000);
      @(negedge clk);
      chk("basic_idle_busy", 32'(bus.busy), 32'd0);
      wait_done();
      fill_tail("basic");
      chk("basic_latency", 32'(done_cyc - miss_cyc), 32'd13);
      chk("basic_meta", 32'(last_meta), 32'h3A3);
      chk("basic_blk", last_meta_blk, 32'h0000_0800);
      chk("basic_tagwr_busy", 32'(bus.busy), 32'd1);
      @(posedge clk);
      #1 bus.miss_detected = 1'b0;
      @(negedge clk);
      chk("basic_post_busy", 32'(bus.busy), 32'd0);
      d0 = done_cnt;
      repeat (3) @(posedge clk);
      #1;
      chk("basic_done_once", 32'(done_cnt), 32'(d0));

      // Back-to-back misses over the index/way corners
      start_fill(16'hFFF0, 1'b1, 16'h2000);
      wait_done();
      fill_tail("b2b_a");
      chk("b2b_a_meta", 32'(last_meta), 32'h3FF);
      chk("b2b_a_blk", last_meta_blk, 32'h8000_0000);
      @(posedge clk);
      #1;
      start_fill(16'h0000, 1'b0, 16'h3000);
      @(negedge clk);
      chk("b2b_idle_gap_busy", 32'(bus.busy), 32'd0);
      wait_done();
      fill_tail("b2b_b");
      chk("b2b_b_meta", 32'(last_meta), 32'h300);
      chk("b2b_b_blk", last_meta_blk, 32'h0000_0001);
      @(posedge clk);
      #1 bus.miss_detected = 1'b0;

      // Irregular returns: latency 1 with 1-3 idle cycles between words
      lat = 1;
      gap_max = 3;
      @(posedge clk);
      #1;
      start_fill(16'h5E70, 1'b0, 16'h4000);
      wait_done();
      fill_tail("gaps");
      @(posedge clk);
      #1 bus.miss_detected = 1'b0;
      lat = 4;
      gap_max = 0;
      repeat (2) @(posedge clk);
      #1;

      // Busy masking: a new miss presented mid-fill must be ignored
      start_fill(16'h1234, 1'b1, 16'h5000);
      repeat (3) @(posedge clk);
      #1 bus.miss_detected = 1'b0;
      @(posedge clk);
      #1;
      bus.miss_detected = 1'b1;
      bus.miss_address = 16'hBEEF;
      bus.victim_way = 1'b0;
      @(posedge clk);
      #1 bus.miss_detected = 1'b0;
      wait_done();
      fill_tail("mask");
      r0 = req_cnt;
      repeat (5) @(posedge clk);
      #1;
      chk("mask_no_new_req", 32'(req_cnt), 32'(r0));

      // Reset after the third return
      start_fill(16'h7720, 1'b0, 16'h6000);
      w0 = we_cnt;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         #1;
         if (we_cnt - w0 >= 3) break;
      end
      chk("rst_mid_progress", 32'(we_cnt - w0), 32'd3);
      #2 rst = 1'b0;
      #1;
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_mem_en", 32'(bus.mem_en), 32'd0);
      chk("arst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("arst_data_we", 32'(bus.data_we), 32'd0);
      chk("arst_data_out", 32'(bus.data_out), 32'd0);
      chk("arst_data_word_en", 32'(bus.data_word_en), 32'd0);
      chk("arst_data_block_en", bus.data_block_en, 32'd0);
      chk("arst_meta_we", 32'(bus.meta_we), 32'd0);
      chk("arst_meta_out", 32'(bus.meta_out), 32'd0);
      chk("arst_fill_done", 32'(bus.fill_done), 32'd0);
      exp_addr_q.delete();
      exp_data_q.delete();
      exp_meta_q.delete();
      bus.miss_detected = 1'b0;
      d0 = done_cnt;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("rst_no_meta_we", 32'(done_cnt), 32'(d0));
      chk("rst_idle_busy", 32'(bus.busy), 32'd0);
      start_fill(16'h7720, 1'b0, 16'h7000);
      wait_done();
      fill_tail("after_rst");
      chk("after_rst_meta", 32'(last_meta), 32'h377);
      chk("after_rst_latency", 32'(done_cyc - miss_cyc), 32'd13);
      @(posedge clk);
      #1 bus.miss_detected = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      chk("final_sb_empty", 32'(exp_addr_q.size() + exp_data_q.size() + exp_meta_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
